// File: rtl/hex_scan_display.sv
// Purpose: time-multiplexed hex display driver with guard band, per-digit blink and leading-zero blanking.
// Latency: outputs are registered. Each output cycle shows the scan position and display register of that same cycle.
// Backpressure: none; LOAD is accepted on every edge and the scan runs freely.
module hex_scan_display #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 1000,
  parameter int GUARD        = 1,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [4*DIGITS-1:0]   DIN,
  input  logic                  LOAD,
  input  logic [DIGITS-1:0]     DP,
  input  logic [DIGITS-1:0]     BLINK,
  input  logic                  BLANK_LZ,
  output logic                  Qa,
  output logic                  Qb,
  output logic                  Qc,
  output logic                  Qd,
  output logic                  Qe,
  output logic                  Qf,
  output logic                  Qg,
  output logic                  Qdp,
  output logic [DIGITS-1:0]     DIG,
  output logic                  FRAME
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] P_LAST  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] P_GUARD = PW'(GUARD);
  localparam logic [KW-1:0] K_LAST  = KW'(DIGITS - 1);
  localparam logic [CW-1:0] C_LAST  = CW'(BLINK_FRAMES - 1);

  // Scan state. r_run is clear until the first edge after reset, so that
  // edge parks the scan at P=0/K=0 instead of advancing past it.
  logic                r_run;
  logic [PW-1:0]       r_p;
  logic [KW-1:0]       r_k;
  logic [CW-1:0]       r_bcnt;
  logic                r_b;
  logic [4*DIGITS-1:0] r_disp;
  logic [DIGITS-1:0]   r_dp;

  // Registered outputs
  logic [6:0]          r_seg;
  logic                r_qdp;
  logic [DIGITS-1:0]   r_dig;
  logic                r_frame;

  // Next-state values; the output registers are loaded from these so that
  // each output cycle matches the state held in that cycle.
  logic                w_tick;
  logic                w_frame_cur;
  logic [PW-1:0]       w_p_nxt;
  logic [KW-1:0]       w_k_nxt;
  logic [CW-1:0]       w_bcnt_nxt;
  logic                w_b_nxt;
  logic [4*DIGITS-1:0] w_disp_nxt;
  logic [DIGITS-1:0]   w_dp_nxt;

  logic [DIGITS-1:0]   w_lz;
  logic                w_zero_run;
  logic                w_blank;
  logic [DIGITS-1:0]   w_dig;
  logic [6:0]          w_seg;
  logic                w_qdp;
  logic                w_frame;

  function automatic logic [6:0] f_seg7(input logic [3:0] i_nib);
    logic [6:0] v_seg;
    case (i_nib)
      4'h0: v_seg = 7'h3F;
      4'h1: v_seg = 7'h06;
      4'h2: v_seg = 7'h5B;
      4'h3: v_seg = 7'h4F;
      4'h4: v_seg = 7'h66;
      4'h5: v_seg = 7'h6D;
      4'h6: v_seg = 7'h7D;
      4'h7: v_seg = 7'h27;
      4'h8: v_seg = 7'h7F;
      4'h9: v_seg = 7'h6F;
      4'hA: v_seg = 7'h77;
      4'hB: v_seg = 7'h7C;
      4'hC: v_seg = 7'h39;
      4'hD: v_seg = 7'h5E;
      4'hE: v_seg = 7'h79;
      default: v_seg = 7'h71;
    endcase
    return v_seg;
  endfunction

  // Advance prescaler, digit index and blink phase; capture the display value on LOAD.
  always_comb begin
    w_tick      = r_run && (r_p == P_LAST);
    w_frame_cur = w_tick && (r_k == K_LAST);
    w_p_nxt     = (!r_run || w_tick) ? '0 : r_p + PW'(1);
    w_k_nxt     = r_k;
    if (w_tick) begin
      w_k_nxt = (r_k == K_LAST) ? '0 : r_k + KW'(1);
    end
    w_bcnt_nxt = r_bcnt;
    w_b_nxt    = r_b;
    if (w_frame_cur) begin
      if (r_bcnt == C_LAST) begin
        w_bcnt_nxt = '0;
        w_b_nxt    = ~r_b;
      end else begin
        w_bcnt_nxt = r_bcnt + CW'(1);
      end
    end
    w_disp_nxt = LOAD ? DIN : r_disp;
    w_dp_nxt   = LOAD ? DP : r_dp;
  end

  // Derive the digit enable, segment code and frame pulse for the upcoming cycle.
  always_comb begin
    // w_lz[i] is set when nibbles i..DIGITS-1 are all zero
    w_lz       = '0;
    w_zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run && (w_disp_nxt[4*i +: 4] == 4'h0);
      w_lz[i]    = w_zero_run;
    end
    w_dig   = (w_p_nxt < P_GUARD) ? '0 : (DIGITS'(1) << w_k_nxt);
    w_frame = (w_p_nxt == P_LAST) && (w_k_nxt == K_LAST);
    // digit 0 is never leading-zero blanked so a zero value still shows "0"
    w_blank = (BLINK[w_k_nxt] && w_b_nxt) ||
              (BLANK_LZ && (w_k_nxt != '0) && w_lz[w_k_nxt]);
    w_seg   = '0;
    w_qdp   = 1'b0;
    if ((w_dig != '0) && !w_blank) begin
      w_seg = f_seg7(w_disp_nxt[{w_k_nxt, 2'b00} +: 4]);
      w_qdp = w_dp_nxt[w_k_nxt];
    end
  end

  // Scan and display state registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_run  <= 1'b0;
      r_p    <= '0;
      r_k    <= '0;
      r_bcnt <= '0;
      r_b    <= 1'b0;
      r_disp <= '0;
      r_dp   <= '0;
    end else begin
      r_run  <= 1'b1;
      r_p    <= w_p_nxt;
      r_k    <= w_k_nxt;
      r_bcnt <= w_bcnt_nxt;
      r_b    <= w_b_nxt;
      r_disp <= w_disp_nxt;
      r_dp   <= w_dp_nxt;
    end
  end

  // Output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_seg   <= '0;
      r_qdp   <= 1'b0;
      r_dig   <= '0;
      r_frame <= 1'b0;
    end else begin
      r_seg   <= w_seg;
      r_qdp   <= w_qdp;
      r_dig   <= w_dig;
      r_frame <= w_frame;
    end
  end

  assign Qa    = r_seg[0];
  assign Qb    = r_seg[1];
  assign Qc    = r_seg[2];
  assign Qd    = r_seg[3];
  assign Qe    = r_seg[4];
  assign Qf    = r_seg[5];
  assign Qg    = r_seg[6];
  assign Qdp   = r_qdp;
  assign DIG   = r_dig;
  assign FRAME = r_frame;

endmodule

// File: tb/tb_hex_scan_display.sv
// Bench for hex_scan_display: directed scenarios followed by random traffic.
// Every output cycle is compared against a cycle-count based reference model.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_hex_scan_display;

  localparam int DIGITS       = 4;
  localparam int PRESCALE     = 4;
  localparam int GUARD        = 1;
  localparam int BLINK_FRAMES = 2;

  logic        CLK      = 1'b0;
  logic        RST_N    = 1'b0;
  logic [15:0] DIN      = '0;
  logic        LOAD     = 1'b0;
  logic [3:0]  DP       = '0;
  logic [3:0]  BLINK    = '0;
  logic        BLANK_LZ = 1'b0;

  wire Qa, Qb, Qc, Qd, Qe, Qf, Qg, Qdp, FRAME;
  wire [3:0] DIG;
  wire [6:0] seg = {Qg, Qf, Qe, Qd, Qc, Qb, Qa};

  hex_scan_display #(
    .DIGITS(DIGITS), .PRESCALE(PRESCALE), .GUARD(GUARD), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .LOAD(LOAD), .DP(DP), .BLINK(BLINK),
    .BLANK_LZ(BLANK_LZ), .Qa(Qa), .Qb(Qb), .Qc(Qc), .Qd(Qd), .Qe(Qe), .Qf(Qf),
    .Qg(Qg), .Qdp(Qdp), .DIG(DIG), .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Reference model: n counts cycles since the first edge after reset (-1 = no edge yet).
  int          n       = -1;
  logic [15:0] m_disp  = '0;
  logic [3:0]  m_dp    = '0;
  logic [3:0]  m_blink = '0;
  logic        m_lzen  = 1'b0;
  logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_dig;
  logic        e_frame;
  logic [6:0]  lz_exp [4] = '{7'h3F, 7'h27, 7'h00, 7'h00};

  function automatic int cur_p();
    return n % PRESCALE;
  endfunction

  function automatic int cur_k();
    return (n / PRESCALE) % DIGITS;
  endfunction

  task automatic model_eval();
    int   p, k, f;
    logic b;
    e_seg = '0; e_dp = 1'b0; e_dig = '0; e_frame = 1'b0;
    if (RST_N && n >= 0) begin
      p = n % PRESCALE;
      k = (n / PRESCALE) % DIGITS;
      f = n / (PRESCALE * DIGITS);
      b = ((f / BLINK_FRAMES) % 2) == 1;
      e_frame = (p == PRESCALE - 1) && (k == DIGITS - 1);
      if (p >= GUARD) begin
        e_dig = 4'(1 << k);
        if (!((m_blink[k] && b) || (m_lzen && k != 0 && (m_disp >> (4 * k)) == 16'h0))) begin
          e_seg = seg_tab[m_disp[4*k +: 4]];
          e_dp  = m_dp[k];
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic check_all();
    model_eval();
    chk("DIG", 32'(DIG), 32'(e_dig));
    chk("SEG", 32'(seg), 32'(e_seg));
    chk("QDP", 32'(Qdp), 32'(e_dp));
    chk("FRAME", 32'(FRAME), 32'(e_frame));
  endtask

  task automatic step();
    @(posedge CLK);
    if (RST_N) begin
      if (LOAD) begin
        m_disp = DIN;
        m_dp   = DP;
      end
      m_blink = BLINK;
      m_lzen  = BLANK_LZ;
      n++;
    end
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #1;
    RST_N  = 1'b0;
    n      = -1;
    m_disp = '0;
    m_dp   = '0;
    #1;
    check_all();
  endtask

  initial begin
    // Reset state, with and without clock edges
    #2;
    check_all();
    chk("RST_DIG", 32'(DIG), 32'h0);
    step();
    step();

    // Release with a load pending on the first edge; full first frame
    DIN = 16'h12AF; DP = 4'b0100; LOAD = 1'b1; RST_N = 1'b1;
    for (int c = 0; c < 16; c++) begin
      step();
      LOAD = 1'b0;
      case (c)
        0:  chk("RST_P0_DIG", 32'(DIG), 32'h0);
        1:  begin chk("RST_P1_DIG", 32'(DIG), 32'h1); chk("DEC_S0", 32'(seg), 32'h71); end
        3:  chk("RST_P3_DIG", 32'(DIG), 32'h1);
        4:  chk("SLOT1_P0_DIG", 32'(DIG), 32'h0);
        5:  begin chk("SLOT1_P1_DIG", 32'(DIG), 32'h2); chk("DEC_S1", 32'(seg), 32'h77); end
        9:  begin chk("DEC_S2", 32'(seg), 32'h5B); chk("DEC_S2_DP", 32'(Qdp), 32'h1); end
        13: chk("DEC_S3", 32'(seg), 32'h06);
        14: chk("FRAME_C15", 32'(FRAME), 32'h0);
        15: chk("FRAME_C16", 32'(FRAME), 32'h1);
        default: ;
      endcase
    end

    // Leading-zero blanking
    BLANK_LZ = 1'b1; DIN = 16'h0070; DP = 4'b0000; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (cur_p() >= GUARD) chk("LZ_0070", 32'(seg), 32'(lz_exp[cur_k()]));
    end
    DIN = 16'h0000; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (cur_p() >= GUARD) chk("LZ_ZERO", 32'(seg), (cur_k() == 0) ? 32'h3F : 32'h0);
    end

    // Blink on digit 0 over six frames
    BLANK_LZ = 1'b0; BLINK = 4'b0001; DIN = 16'h8888; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    repeat (96) step();

    // Load in the middle of slot 0
    BLINK = 4'b0000;
    step();
    for (int i = 0; i < 20 && !(cur_k() == 0 && cur_p() == 2); i++) step();
    DIN = 16'h0005; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    chk("MIDLOAD", 32'(seg), 32'h6D);
    step();

    // Reset in the middle of slot 2
    for (int i = 0; i < 20 && !(cur_k() == 2 && cur_p() == 2); i++) step();
    async_reset();
    chk("MIDRST_DIG", 32'(DIG), 32'h0);
    chk("MIDRST_FRAME", 32'(FRAME), 32'h0);
    step();
    RST_N = 1'b1;
    step();
    step();
    chk("MIDRST_RESTART_DIG", 32'(DIG), 32'h1);
    chk("MIDRST_DISP_ZERO", 32'(seg), 32'h3F);

    // Random traffic with occasional asynchronous reset
    for (int c = 0; c < 600; c++) begin
      LOAD = ($urandom_range(0, 3) == 0);
      DIN  = 16'($urandom) >> (4 * $urandom_range(0, 4));
      DP   = 4'($urandom);
      if ($urandom_range(0, 31) == 0) BLINK = 4'($urandom);
      if ($urandom_range(0, 31) == 0) BLANK_LZ = 1'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
        step();
        RST_N = 1'b1;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
